pll_rst_seq: RTL

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

---
 rtl/pll_rst_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pll_rst_seq.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the downstream domain resets one at a time, retrying or faulting on timeout.
module pll_rst_seq #(
    parameter int NUM_DOMAINS      = 3,
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int STAGE_GAP_CYC    = 8,
    parameter int MAX_RETRY        = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   pll_lock_in,
    input  logic                   soft_rst_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rstn,
    output logic                   ready,
    output logic                   fault,
    output logic [3:0]             retry_cnt,
    output logic [7:0]             lock_loss_cnt
);

    // state     | meaning
    // RST_PLL   | pll_rst held high for RST_PULSE_CYC cycles
    // WAIT_LOCK | pll_rst released, waiting for lock or timeout
    // STABLE    | lock seen, counting consecutive locked cycles
    // RELEASE   | domain resets released one by one, STAGE_GAP_CYC apart
    // RUN       | all domains out of reset, ready high
    // FAULT     | retries exhausted, waiting for soft_rst_req
    typedef enum logic [2:0] {
        RST_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT
    } state_t;

    localparam int RELEASE_LEN = NUM_DOMAINS * STAGE_GAP_CYC;
    localparam int MAX_A   = (LOCK_TIMEOUT_CYC > LOCK_STABLE_CYC) ? LOCK_TIMEOUT_CYC : LOCK_STABLE_CYC;
    localparam int MAX_B   = (RST_PULSE_CYC > RELEASE_LEN) ? RST_PULSE_CYC : RELEASE_LEN;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_LEN - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   sync1_q, sync2_q;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic [3:0]             retry_q, retry_d;
    logic [7:0]             loss_q, loss_d;
    logic                   lock;

    assign lock    = sync2_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        dom_d   = dom_q;
        case (state_q)
            RST_PLL: begin
                dom_d = '0;
                if (cnt_q == PULSE_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_LOCK: begin
                if (lock) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + 4'd1;
                    cnt_d   = '0;
                    state_d = (retry_d == 4'(MAX_RETRY)) ? FAULT : RST_PLL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STABLE: begin
                if (!lock) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d  = RELEASE;
                    cnt_d    = '0;
                    dom_d[0] = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE: begin
                if (!lock) begin
                    state_d = RST_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                    dom_d   = '0;
                end else if (cnt_q == RELEASE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    // Bits only ever get set here, so release order is monotonic.
                    for (int k = 1; k < NUM_DOMAINS; k++) begin
                        if (cnt_inc == CNT_W'(k * STAGE_GAP_CYC)) dom_d[k] = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!lock) begin
                    state_d = RST_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                    dom_d   = '0;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            FAULT: begin
                dom_d = '0;
            end
            default: begin
                state_d = RST_PLL;
                cnt_d   = '0;
                dom_d   = '0;
            end
        endcase

        if (soft_rst_req) begin
            state_d = RST_PLL;
            cnt_d   = '0;
            retry_d = '0;
            dom_d   = '0;
            loss_d  = loss_q;
        end

        pll_rst_d = (state_d == RST_PLL) || (state_d == FAULT);
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= RST_PLL;
            cnt_q     <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            retry_q   <= '0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= pll_lock_in;
            sync2_q   <= sync1_q;
            pll_rst_q <= pll_rst_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign domain_rstn   = dom_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule
